// File: rtl/sd_sec_stream_reader.sv
// Streams a run of SD sectors from the card controller into a FWFT FIFO of 32-bit words.
// Optional macro SD_STREAM_BIG_ENDIAN_EN puts the first byte of each word in bits [31:24].
module sd_sec_stream_reader #(
  parameter int FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_sector,
  input  logic [15:0] sector_count,
  output logic        busy,
  output logic        done,
  input  logic        sd_init_done,
  output logic        sd_sec_read,
  output logic [31:0] sd_sec_read_addr,
  input  logic [7:0]  sd_sec_read_data,
  input  logic        sd_sec_read_data_valid,
  input  logic        sd_sec_read_end,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // A sector yields 128 words, so a read may only start while that much room is left.
  localparam logic [AW+1:0] OCC_LIMIT = (AW+2)'(FIFO_DEPTH - 128);

  typedef enum logic [2:0] {IDLE, WAIT_INIT, WAIT_SPACE, READ, NEXT, FINISH} state_t;

  state_t      state;
  logic [15:0] remaining;

  logic [1:0]  byte_idx;
  logic [9:0]  byte_cnt;
  logic [31:0] pack_p0;
  logic        vld_p1;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          in_read;
  logic          take;
  logic          push;
  logic          pop;
  logic [AW+1:0] occupied;
  logic          space_ok;

  function automatic logic [31:0] pack_byte(input logic [31:0] acc, input logic [7:0] b);
`ifdef SD_STREAM_BIG_ENDIAN_EN
    return {acc[23:0], b};
`else
    return {b, acc[31:8]};
`endif
  endfunction

  assign in_read  = (state == READ);
  assign take     = in_read && sd_sec_read_data_valid && !byte_cnt[9];
  assign push     = vld_p1;
  assign pop      = out_valid && out_ready;
  assign occupied = {1'b0, count} + {{(AW+1){1'b0}}, vld_p1};
  assign space_ok = (occupied <= OCC_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      sd_sec_read      <= 1'b0;
      sd_sec_read_addr <= '0;
      remaining        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sd_sec_read_addr <= start_sector;
            remaining        <= sector_count;
            busy             <= 1'b1;
            state            <= (sector_count == 16'd0) ? FINISH : WAIT_INIT;
          end
        end
        WAIT_INIT: begin
          if (sd_init_done) state <= WAIT_SPACE;
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            sd_sec_read <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          if (sd_sec_read_end) begin
            sd_sec_read      <= 1'b0;
            remaining        <= remaining - 16'd1;
            sd_sec_read_addr <= sd_sec_read_addr + 32'd1;
            state            <= NEXT;
          end
        end
        NEXT: begin
          state <= (remaining == 16'd0) ? FINISH : WAIT_SPACE;
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: byte assembly; the end pulse restarts the lane and per-sector counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= '0;
      byte_cnt <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (in_read && sd_sec_read_end) begin
        byte_idx <= '0;
        byte_cnt <= '0;
      end else if (take) begin
        byte_idx <= byte_idx + 2'd1;
        byte_cnt <= byte_cnt + 10'd1;
        if (byte_idx == 2'd3) vld_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take) pack_p0 <= pack_byte(pack_p0, sd_sec_read_data);
  end

  // Stage p1: the completed word lands in the FIFO one cycle after its last byte.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pack_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_sd_sec_stream_reader.sv
// Directed bench for sd_sec_stream_reader with a behavioural SD sector source.
module tb_sd_sec_stream_reader;

  localparam int FIFO_DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_sector = '0;
  logic [15:0] sector_count = '0;
  logic        busy;
  logic        done;
  logic        sd_init_done = 1'b1;
  logic        sd_sec_read;
  logic [31:0] sd_sec_read_addr;
  logic [7:0]  sd_sec_read_data = '0;
  logic        sd_sec_read_data_valid = 1'b0;
  logic        sd_sec_read_end = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int checks = 0;
  int passed = 0;

  sd_sec_stream_reader #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_sector(start_sector),
    .sector_count(sector_count), .busy(busy), .done(done),
    .sd_init_done(sd_init_done), .sd_sec_read(sd_sec_read),
    .sd_sec_read_addr(sd_sec_read_addr), .sd_sec_read_data(sd_sec_read_data),
    .sd_sec_read_data_valid(sd_sec_read_data_valid), .sd_sec_read_end(sd_sec_read_end),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Card model: one sector of bytes 0..255 repeated per read request, then an end pulse.
  logic [31:0] addr_log[$];
  int  m_idx = 0;
  bit  m_busy = 0, m_fin = 0, m_tog = 0;
  int  m_extra = 0;
  bit  m_gap = 0, m_junk = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_fin = 0;
      sd_sec_read_data_valid = 1'b0; sd_sec_read_end = 1'b0;
    end else if (!sd_sec_read) begin
      m_busy = 0; m_fin = 0; sd_sec_read_end = 1'b0;
      sd_sec_read_data_valid = m_junk;
      sd_sec_read_data = m_junk ? 8'hEE : 8'h00;
    end else if (m_fin) begin
      sd_sec_read_data_valid = 1'b0; sd_sec_read_end = 1'b0;
    end else if (!m_busy) begin
      m_busy = 1; m_idx = 0; m_tog = 0;
      addr_log.push_back(sd_sec_read_addr);
      sd_sec_read_data_valid = 1'b0;
    end else if (m_idx < 512 + m_extra) begin
      if (m_gap && m_tog) begin
        sd_sec_read_data_valid = 1'b0; m_tog = 0;
      end else begin
        sd_sec_read_data = m_idx[7:0];
        sd_sec_read_data_valid = 1'b1;
        m_idx++; m_tog = 1;
      end
    end else begin
      sd_sec_read_data_valid = 1'b0; sd_sec_read_end = 1'b1; m_fin = 1;
    end
  end

  // Monitor: collects accepted words, done pulses and invariant violations.
  logic [31:0] words[$];
  int  done_pulses = 0;
  bit  rd_seen = 0;
  bit  push_full_seen = 0;
  bit  addr_unstable = 0;
  bit  prev_rd = 0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    #3;
    if (out_valid && out_ready) words.push_back(out_data);
    if (done) done_pulses++;
    if (sd_sec_read) rd_seen = 1;
    if (sd_sec_read && prev_rd && sd_sec_read_addr != prev_addr) addr_unstable = 1;
    if (dut.vld_p1 && dut.count == FIFO_DEPTH && !(out_valid && out_ready)) push_full_seen = 1;
    prev_rd = sd_sec_read;
    prev_addr = sd_sec_read_addr;
  end

  function automatic logic [31:0] exp_word(input int i);
    logic [7:0] b0;
    b0 = 8'((4 * i) & 255);
`ifdef SD_STREAM_BIG_ENDIAN_EN
    return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
`else
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
`endif
  endfunction

  function automatic int bad_words();
    int bad = 0;
    for (int i = 0; i < words.size(); i++)
      if (words[i] !== exp_word(i)) bad++;
    return bad;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    addr_log.delete();
    words.delete();
    done_pulses = 0;
    rd_seen = 0;
  endtask

  task automatic pulse_start(input logic [31:0] addr, input logic [15:0] cnt);
    @(negedge clk);
    start_sector = addr;
    sector_count = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (done) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (sd_sec_read !== 1'b0) $display("FAIL rst_sd_sec_read: got %b want 0", sd_sec_read); else passed++;
    checks++; if (sd_sec_read_addr !== 32'h0) $display("FAIL rst_addr: got %h want 00000000", sd_sec_read_addr); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 00000000", out_data); else passed++;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if ({busy, done, sd_sec_read, out_valid} !== 4'b0) $display("FAIL post_rst_outputs: got %b want 0000", {busy, done, sd_sec_read, out_valid}); else passed++;
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    out_ready = 1'b1;
    pulse_start(32'h100, 16'd2);
    repeat (50) @(negedge clk);
    pulse_start(32'h999, 16'd5);
    wait_done(5000, ok);
    checks++; if (ok !== 1'b1) $display("FAIL basic_done_timeout: got %b want 1", ok); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after_done: got %b want 0", busy); else passed++;
    repeat (300) @(negedge clk);
    checks++; if (addr_log.size() !== 2) $display("FAIL basic_sector_reads: got %0d want 2", addr_log.size()); else passed++;
    checks++; if (log_at(0) !== 32'h100) $display("FAIL basic_addr0: got %h want 00000100", log_at(0)); else passed++;
    checks++; if (log_at(1) !== 32'h101) $display("FAIL basic_addr1: got %h want 00000101", log_at(1)); else passed++;
    checks++; if (words.size() !== 256) $display("FAIL basic_word_count: got %0d want 256", words.size()); else passed++;
    checks++; if (words.size() == 0 || words[0] !== exp_word(0)) $display("FAIL basic_first_word: got %h want %h", words.size() ? words[0] : 32'hx, exp_word(0)); else passed++;
    checks++; if (bad_words() !== 0) $display("FAIL basic_word_order: got %0d bad words want 0", bad_words()); else passed++;
    checks++; if (done_pulses !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_pulses); else passed++;
  endtask

  task automatic test_zero_count();
    clear_logs();
    pulse_start(32'h55, 16'd0);
    #1;
    checks++; if ({busy, done} !== 2'b10) $display("FAIL zero_cycle1 busy,done: got %b want 10", {busy, done}); else passed++;
    @(negedge clk); #1;
    checks++; if ({busy, done} !== 2'b01) $display("FAIL zero_cycle2 busy,done: got %b want 01", {busy, done}); else passed++;
    @(negedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (rd_seen !== 1'b0) $display("FAIL zero_no_read: got %b want 0", rd_seen); else passed++;
    checks++; if (done_pulses !== 1) $display("FAIL zero_done_pulses: got %0d want 1", done_pulses); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    pulse_start(32'h200, 16'd3);
    repeat (3000) @(negedge clk);
    #1;
    checks++; if (addr_log.size() !== 2) $display("FAIL bp_held_sectors: got %0d want 2", addr_log.size()); else passed++;
    checks++; if ({busy, sd_sec_read, out_valid} !== 3'b101) $display("FAIL bp_held_state busy,rd,valid: got %b want 101", {busy, sd_sec_read, out_valid}); else passed++;
    checks++; if (dut.count !== 9'(FIFO_DEPTH)) $display("FAIL bp_fifo_full: got %0d want %0d", dut.count, FIFO_DEPTH); else passed++;
    checks++; if (words.size() !== 0) $display("FAIL bp_no_pop: got %0d want 0", words.size()); else passed++;
    out_ready = 1'b1;
    wait_done(5000, ok);
    checks++; if (ok !== 1'b1) $display("FAIL bp_done_timeout: got %b want 1", ok); else passed++;
    repeat (300) @(negedge clk);
    checks++; if (log_at(2) !== 32'h202) $display("FAIL bp_third_addr: got %h want 00000202", log_at(2)); else passed++;
    checks++; if (words.size() !== 384) $display("FAIL bp_word_count: got %0d want 384", words.size()); else passed++;
    checks++; if (bad_words() !== 0) $display("FAIL bp_word_order: got %0d bad words want 0", bad_words()); else passed++;
  endtask

  task automatic test_init_wait();
    bit ok;
    clear_logs();
    sd_init_done = 1'b0;
    pulse_start(32'h40, 16'd1);
    repeat (1000) @(negedge clk);
    #1;
    checks++; if (rd_seen !== 1'b0) $display("FAIL init_no_read: got %b want 0", rd_seen); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL init_busy: got %b want 1", busy); else passed++;
    sd_init_done = 1'b1;
    wait_done(3000, ok);
    checks++; if (ok !== 1'b1) $display("FAIL init_done_timeout: got %b want 1", ok); else passed++;
    repeat (300) @(negedge clk);
    checks++; if (log_at(0) !== 32'h40) $display("FAIL init_addr: got %h want 00000040", log_at(0)); else passed++;
    checks++; if (words.size() !== 128 || bad_words() !== 0) $display("FAIL init_words: got %0d words, %0d bad want 128, 0", words.size(), bad_words()); else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    m_extra = 8; m_gap = 1; m_junk = 1;
    pulse_start(32'hFFFF_FFFF, 16'd2);
    wait_done(8000, ok);
    checks++; if (ok !== 1'b1) $display("FAIL wrap_done_timeout: got %b want 1", ok); else passed++;
    repeat (300) @(negedge clk);
    m_extra = 0; m_gap = 0; m_junk = 0;
    checks++; if (log_at(0) !== 32'hFFFF_FFFF) $display("FAIL wrap_addr0: got %h want ffffffff", log_at(0)); else passed++;
    checks++; if (log_at(1) !== 32'h0) $display("FAIL wrap_addr1: got %h want 00000000", log_at(1)); else passed++;
    checks++; if (words.size() !== 256) $display("FAIL wrap_word_count: got %0d want 256", words.size()); else passed++;
    checks++; if (bad_words() !== 0) $display("FAIL wrap_word_order: got %0d bad words want 0", bad_words()); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    out_ready = 1'b0;
    pulse_start(32'h300, 16'd1);
    repeat (200) @(negedge clk);
    #1;
    checks++; if ({sd_sec_read, out_valid} !== 2'b11) $display("FAIL mid_precondition rd,valid: got %b want 11", {sd_sec_read, out_valid}); else passed++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (sd_sec_read !== 1'b0) $display("FAIL mid_rst_rd: got %b want 0", sd_sec_read); else passed++;
    checks++; if (sd_sec_read_addr !== 32'h0) $display("FAIL mid_rst_addr: got %h want 00000000", sd_sec_read_addr); else passed++;
    checks++; if ({busy, done, out_valid} !== 3'b000) $display("FAIL mid_rst_flags busy,done,valid: got %b want 000", {busy, done, out_valid}); else passed++;
    checks++; if (out_data !== 32'h0) $display("FAIL mid_rst_out_data: got %h want 00000000", out_data); else passed++;
    repeat (20) @(negedge clk);
    clear_logs();
    out_ready = 1'b1;
    pulse_start(32'h400, 16'd1);
    wait_done(3000, ok);
    checks++; if (ok !== 1'b1) $display("FAIL mid_restart_timeout: got %b want 1", ok); else passed++;
    repeat (300) @(negedge clk);
    checks++; if (addr_log.size() !== 1 || log_at(0) !== 32'h400) $display("FAIL mid_restart_addr: got %h (%0d reads) want 00000400 (1)", log_at(0), addr_log.size()); else passed++;
    checks++; if (words.size() !== 128 || bad_words() !== 0) $display("FAIL mid_restart_words: got %0d words, %0d bad want 128, 0", words.size(), bad_words()); else passed++;
  endtask

  task automatic test_invariants();
    checks++; if (push_full_seen !== 1'b0) $display("FAIL push_into_full: got %b want 0", push_full_seen); else passed++;
    checks++; if (addr_unstable !== 1'b0) $display("FAIL addr_stable_during_read: got %b want 0", addr_unstable); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_init_wait();
    test_wrap();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
